multi_precision_adder_ctrl: RTL and testbench
=============================================

// Module: multi_precision_adder_ctrl
// PURPOSE
// - Sequences one DATA_WIDTH-bit ripple_carry_adder over CHUNKS words.
// - Adds or subtracts two DATA_WIDTH*CHUNKS-bit operands, processing one word per cycle.
// - The carry is registered between words.
// - Sits between a wide-operand requester (valid/ready) and the narrow adder datapath.
// PARAMETERS
// - DATA_WIDTH : 32 : width of the instantiated adder (one chunk)
// - CHUNKS     : 4  : number of chunks, >= 1; TOTAL_WIDTH = DATA_WIDTH*CHUNKS (localparam)
// PORTS
// - clk_i        in   1            clock, rising edge
// - rst_n_i      in   1            reset, asynchronous, active-low
// - operand_A_i  in   TOTAL_WIDTH  minuend / addend A
// - operand_B_i  in   TOTAL_WIDTH  subtrahend / addend B
// - carry_i      in   1            carry-in (add) or borrow-in (subtract)
// - subtract_i   in   1            1: A - B - carry_i; 0: A + B + carry_i
// - valid_i      in   1            request valid
// - ready_o      out  1            controller can accept a request
// - result_o     out  TOTAL_WIDTH  result, LSB chunk = chunk 0
// - carry_o      out  1            carry-out (add), NOT-borrow (subtract)
// - valid_o      out  1            result_o/carry_o valid
// - ready_i      in   1            consumer accepts result
// BEHAVIOUR
// - FSM states: IDLE, COMPUTE, DONE.
// - ready_o = (state == IDLE), decoded combinationally from state.
// - IDLE:
//   - On valid_i & ready_o, latch A, and B (inverted when subtract_i).
//   - Set the carry reg to carry_i ^ subtract_i.
//   - Clear the chunk index and go to COMPUTE.
// - COMPUTE:
//   - The adder takes A[idx], Bx[idx] and the carry reg.
//   - result_o[idx] <= sum; carry reg <= adder carry-out; idx++.
//   - When idx == CHUNKS-1, write the last chunk and carry_o, then go to DONE.
// - DONE: valid_o = 1. On ready_i, go to IDLE; valid_o drops next cycle.
// - Latency: valid_o rises CHUNKS cycles after the accepting edge.
//   - Min initiation interval: CHUNKS+2 cycles.
// - Arithmetic:
//   - Result is modulo 2^TOTAL_WIDTH.
//   - carry_o is the carry out of the MSB chunk.
//   - In subtract mode, carry_o=0 means a borrow occurred.
// - Input sampling: inputs are sampled only on the accepting edge.
//   - valid_i/operand changes in COMPUTE or DONE are ignored (not queued).
// - Output stability:
//   - result_o and carry_o hold from DONE until the next acceptance.
//   - result_o is partially updated (not valid) while in COMPUTE.
// - Backpressure: DONE is held indefinitely while ready_i=0; outputs stay stable.
// - CHUNKS=1: one COMPUTE cycle, then DONE.
// - Reset values (asserted asynchronously):
//   - state=IDLE, idx=0, carry reg=0.
//   - result_o=0, carry_o=0, valid_o=0, ready_o=1.
// - Reset mid-operation aborts immediately; no valid_o is produced for the aborted request.
// - The idx counter width is max(1,$clog2(CHUNKS)); idx never exceeds CHUNKS-1.
// TESTING (DATA_WIDTH=8, CHUNKS=4 unless noted)
// - Add, carry across chunks:
//   - A=0x000000FF, B=0x00000001, cin=0.
//   - Expect result 0x00000100, carry_o=0, valid_o 4 cycles after accept.
// - Add, full wrap:
//   - A=0xFFFFFFFF, B=0x00000001, cin=0.
//   - Expect result 0x00000000, carry_o=1.
// - Subtract, borrow:
//   - sub=1, A=0x00000005, B=0x00000007, cin=0.
//   - Expect result 0xFFFFFFFE, carry_o=0.
//   - Same request with A=7, B=5: expect 0x00000002, carry_o=1.
// - Backpressure:
//   - Hold ready_i=0 for 5 cycles in DONE; pulse valid_i with new operands.
//   - Expect result/valid_o stable, ready_o=0, and the pulse ignored.
// - Reset:
//   - Drop rst_n_i while idx=2.
//   - Expect all outputs at reset values immediately, ready_o=1 after release, no valid_o.
// - CHUNKS=1 build:
//   - A=0x80, B=0x80, cin=1.
//   - Expect result 0x01, carry_o=1, valid_o 1 cycle after accept.

Source files
------------

// File: rtl/multi_precision_adder_ctrl.sv
// Wide add/subtract built from one narrow ripple-carry adder, one chunk per cycle.
// The carry between chunks is held in a register.

module ripple_carry_adder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  carry_i,
   output logic [DATA_WIDTH-1:0] sum_o,
   output logic                  carry_o
);

   logic [DATA_WIDTH:0] c;

   assign c[0] = carry_i;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign carry_o = c[DATA_WIDTH];

endmodule

// state   | meaning
// IDLE    | ready_o=1, waiting for valid_i
// COMPUTE | adding chunk idx, carry registered between chunks
// DONE    | valid_o=1, holding result until ready_i
module multi_precision_adder_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNKS      = 4,
   localparam int TOTAL_WIDTH = DATA_WIDTH * CHUNKS
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [TOTAL_WIDTH-1:0] operand_A_i,
   input  logic [TOTAL_WIDTH-1:0] operand_B_i,
   input  logic                   carry_i,
   input  logic                   subtract_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [TOTAL_WIDTH-1:0] result_o,
   output logic                   carry_o,
   output logic                   valid_o,
   input  logic                   ready_i
);

   localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic                              carry_q, carry_d;
   logic                              cout_q, cout_d;
   logic [CHUNKS-1:0][DATA_WIDTH-1:0] a_q, a_d;
   logic [CHUNKS-1:0][DATA_WIDTH-1:0] b_q, b_d;
   logic [CHUNKS-1:0][DATA_WIDTH-1:0] result_q, result_d;

   logic [DATA_WIDTH-1:0] a_chunk;
   logic [DATA_WIDTH-1:0] b_chunk;
   logic [DATA_WIDTH-1:0] sum_chunk;
   logic                  add_cout;

   // Chunk select by compare keeps the CHUNKS=1 build free of index-width issues.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < CHUNKS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_chunk = a_q[i];
            b_chunk = b_q[i];
         end
      end
   end

   ripple_carry_adder #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_adder (
      .a_i     (a_chunk),
      .b_i     (b_chunk),
      .carry_i (carry_q),
      .sum_o   (sum_chunk),
      .carry_o (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               a_d     = operand_A_i;
               // Subtract is A + ~B + 1 - borrow_in, so fold both into the carry.
               b_d     = subtract_i ? ~operand_B_i : operand_B_i;
               carry_d = carry_i ^ subtract_i;
               idx_d   = '0;
               state_d = S_COMPUTE;
            end
         end

         S_COMPUTE: begin
            for (int i = 0; i < CHUNKS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  result_d[i] = sum_chunk;
               end
            end
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign valid_o  = (state_q == S_DONE);
   assign result_o = result_q;
   assign carry_o  = cout_q;

endmodule

// File: tb/tb_multi_precision_adder_ctrl.sv
// Bench for multi_precision_adder_ctrl: 8-bit x 4 chunk instance plus a single-chunk instance.

module tb_multi_precision_adder_ctrl;

   localparam int DW  = 8;
   localparam int CH  = 4;
   localparam int TW  = DW * CH;
   localparam int TW1 = DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [TW-1:0] op_a, op_b, result;
   logic          cin, sub, valid_in, ready_out, cout, valid_out, ready_in;

   logic [TW1-1:0] op_a1, op_b1, result1;
   logic           cin1, sub1, valid_in1, ready_out1, cout1, valid_out1, ready_in1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_precision_adder_ctrl #(.DATA_WIDTH(DW), .CHUNKS(CH)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .operand_A_i (op_a),
      .operand_B_i (op_b),
      .carry_i     (cin),
      .subtract_i  (sub),
      .valid_i     (valid_in),
      .ready_o     (ready_out),
      .result_o    (result),
      .carry_o     (cout),
      .valid_o     (valid_out),
      .ready_i     (ready_in)
   );

   multi_precision_adder_ctrl #(.DATA_WIDTH(DW), .CHUNKS(1)) dut1 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .operand_A_i (op_a1),
      .operand_B_i (op_b1),
      .carry_i     (cin1),
      .subtract_i  (sub1),
      .valid_i     (valid_in1),
      .ready_o     (ready_out1),
      .result_o    (result1),
      .carry_o     (cout1),
      .valid_o     (valid_out1),
      .ready_i     (ready_in1)
   );

   typedef struct {
      logic [TW-1:0] a;
      logic [TW-1:0] b;
      logic          cin;
      logic          sub;
      logic [TW-1:0] exp_r;
      logic          exp_c;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; subtract carry is "no borrow".
   function automatic logic [TW:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                         input logic c, input logic s);
      longint unsigned av = longint'(a);
      longint unsigned bv = longint'(b);
      longint unsigned cv = longint'(c);
      longint unsigned r;
      if (!s) begin
         r = av + bv + cv;
         return r[TW:0];
      end
      r = (av - bv - cv) & 64'h0000_0000_FFFF_FFFF;
      return {(av >= bv + cv), r[TW-1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request and wait for valid_o; returns cycles from accept to valid_o.
   task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                        input logic s, output int lat);
      int n = 0;
      while (!ready_out && n < 20) begin
         tick();
         n++;
      end
      chk("ready_before_req", 64'(ready_out), 64'd1);
      op_a = a; op_b = b; cin = c; sub = s; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!valid_out && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk("valid_drop", 64'(valid_out), 64'd0);
      chk("ready_back", 64'(ready_out), 64'd1);
   endtask

   initial begin
      int lat;
      logic [TW:0]   m;
      logic [TW-1:0] held;

      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
      vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
      vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1};
      vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0};
      vecs[5] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};
      vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
      vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1};

      rst_n = 1'b0; op_a = '0; op_b = '0; cin = 0; sub = 0; valid_in = 0; ready_in = 0;
      op_a1 = '0; op_b1 = '0; cin1 = 0; sub1 = 0; valid_in1 = 0; ready_in1 = 0;
      #12;
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_carry", 64'(cout), 64'd0);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_ready", 64'(ready_out), 64'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(CH));
         chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp_r));
         chk($sformatf("vec%0d_carry", i), 64'(cout), 64'(vecs[i].exp_c));
         consume();
      end

      // Backpressure: hold DONE, pulse valid_i with other operands.
      issue(32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0, lat);
      held = result;
      chk("bp_result", 64'(result), 64'h1112_1314);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; valid_in = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         tick();
         chk("bp_valid", 64'(valid_out), 64'd1);
         chk("bp_ready", 64'(ready_out), 64'd0);
         chk("bp_stable", 64'(result), 64'(held));
      end
      valid_in = 1'b0;
      consume();
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("bp_pulse_ignored", 64'(valid_out), 64'd0);
      end
      chk("bp_hold_after", 64'(result), 64'(held));

      // Reset while idx=2: two chunks already written into result_o.
      op_a = 32'hFFFF_FFFF; op_b = 32'h0; cin = 0; sub = 0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      chk("partial_update", 64'(result[15:0]), 64'hFFFF);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result", 64'(result), 64'd0);
      chk("mid_rst_carry", 64'(cout), 64'd0);
      chk("mid_rst_valid", 64'(valid_out), 64'd0);
      chk("mid_rst_ready", 64'(ready_out), 64'd1);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("post_rst_no_valid", 64'(valid_out), 64'd0);
         chk("post_rst_ready", 64'(ready_out), 64'd1);
      end

      // Randomized traffic against the arithmetic model, with random consumer stall.
      for (int i = 0; i < 40; i++) begin
         logic [TW-1:0] ra, rb;
         logic          rc, rs;
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         if (i % 8 == 0) rb = ra;
         m = model(ra, rb, rc, rs);
         issue(ra, rb, rc, rs, lat);
         chk("rnd_latency", 64'(lat), 64'(CH));
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            tick();
         end
         chk("rnd_result", 64'(result), 64'(m[TW-1:0]));
         chk("rnd_carry", 64'(cout), 64'(m[TW]));
         consume();
      end

      // Single-chunk build.
      op_a1 = 8'h80; op_b1 = 8'h80; cin1 = 1'b1; sub1 = 1'b0; valid_in1 = 1'b1;
      tick();
      valid_in1 = 1'b0;
      lat = 0;
      while (!valid_out1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("c1_latency", 64'(lat), 64'd1);
      chk("c1_result", 64'(result1), 64'h01);
      chk("c1_carry", 64'(cout1), 64'd1);
      ready_in1 = 1'b1;
      tick();
      ready_in1 = 1'b0;
      chk("c1_valid_drop", 64'(valid_out1), 64'd0);
      tick();
      op_a1 = 8'h03; op_b1 = 8'h05; cin1 = 1'b0; sub1 = 1'b1; valid_in1 = 1'b1;
      tick();
      valid_in1 = 1'b0;
      lat = 0;
      while (!valid_out1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("c1_sub_latency", 64'(lat), 64'd1);
      chk("c1_sub_result", 64'(result1), 64'hFE);
      chk("c1_sub_carry", 64'(cout1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
